// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Integer register file with per-register scoreboard busy bits.
//               Two independent combinational read ports, one writeback port,
//               one issue port that marks a destination busy until written
//               back, a flush that discards all pending producers, and a
//               registered count of busy registers.
//
//   Ports
//     clk                 rising-edge clock for all state
//     rst                 synchronous reset, active low
//     rSel1 / rSel2       read selects
//     rs1Data / rs2Data   read data (combinational from select)
//     rs1Busy / rs2Busy   selected register has a pending producer
//     wCtrl/wSel/wData    writeback port
//     issueValid/issueRd  producer issued that will later write issueRd
//     flush               clear every busy bit
//     busyCount           number of registers currently busy
//
// Revision    : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rSel1,
    input  logic [AW-1:0]   rSel2,
    output logic [XLEN-1:0] rs1Data,
    output logic [XLEN-1:0] rs2Data,
    output logic            rs1Busy,
    output logic            rs2Busy,
    input  logic            wCtrl,
    input  logic [AW-1:0]   wSel,
    input  logic [XLEN-1:0] wData,
    input  logic            issueValid,
    input  logic [AW-1:0]   issueRd,
    input  logic            flush,
    output logic [AW:0]     busyCount
);

    localparam logic [AW-1:0] c_zeroIdx = '0;

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busyCount;

    logic            w_wrActive;
    logic            w_issueActive;
    logic            w_setInc;
    logic            w_clrDec;
    logic [NREG-1:0] w_busyNext;

    // Register 0 is hard-wired: writes and issues targeting it are dropped.
    assign w_wrActive    = wCtrl && (wSel != c_zeroIdx);
    assign w_issueActive = issueValid && (issueRd != c_zeroIdx);

    // Busy-bit priority: flush, then issue set, then writeback clear.
    always_comb begin
        w_busyNext = r_busy;
        if (flush) begin
            w_busyNext = '0;
        end else begin
            if (w_wrActive) begin
                w_busyNext[wSel] = 1'b0;
            end
            if (w_issueActive) begin
                w_busyNext[issueRd] = 1'b1;
            end
        end
        w_busyNext[0] = 1'b0;
    end

    // Incremental count: a set only counts on a 0->1 transition, a clear only
    // on a 1->0 transition that is not overridden by a same-register issue.
    assign w_setInc = w_issueActive && !r_busy[issueRd];
    assign w_clrDec = w_wrActive && r_busy[wSel]
                      && !(w_issueActive && (issueRd == wSel));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy      <= '0;
            r_busyCount <= '0;
        end else begin
            if (w_wrActive) begin
                r_regs[wSel] <= wData;
            end
            r_busy <= w_busyNext;
            if (flush) begin
                r_busyCount <= '0;
            end else begin
                r_busyCount <= r_busyCount + (AW+1)'(w_setInc)
                                           - (AW+1)'(w_clrDec);
            end
        end
    end

    assign busyCount = r_busyCount;

    // Forwarding hit: an in-flight write to the selected register.
    function automatic logic bypassHit(input logic [AW-1:0] sel);
        return (BYPASS != 0) && w_wrActive && (sel == wSel);
    endfunction

    function automatic logic [XLEN-1:0] readData(input logic [AW-1:0] sel);
        if (sel == c_zeroIdx) begin
            return '0;
        end else if (bypassHit(sel)) begin
            return wData;
        end else begin
            return r_regs[sel];
        end
    endfunction

    // A forwarded value is by definition the producer's result, so it is
    // reported not-busy even when the stored busy bit is still set.
    function automatic logic readBusy(input logic [AW-1:0] sel);
        if ((sel == c_zeroIdx) || bypassHit(sel)) begin
            return 1'b0;
        end else begin
            return r_busy[sel];
        end
    endfunction

    assign rs1Data = readData(rSel1);
    assign rs2Data = readData(rSel2);
    assign rs1Busy = readBusy(rSel1);
    assign rs2Busy = readBusy(rSel2);

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb. Two instances share all
//               inputs: one with forwarding enabled, one without. Outputs are
//               compared against an array-based reference model of the
//               register file and scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

    localparam int c_xlen = 32;
    localparam int c_nreg = 32;
    localparam int c_aw   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_aw-1:0]   rSel1, rSel2, wSel, issueRd;
    logic [c_xlen-1:0] wData;
    logic              wCtrl, issueValid, flush;

    logic [c_xlen-1:0] rs1Data, rs2Data, rs1Data0, rs2Data0;
    logic              rs1Busy, rs2Busy, rs1Busy0, rs2Busy0;
    logic [c_aw:0]     busyCount, busyCount0;

    int checks = 0;
    int errors = 0;

    logic [c_xlen-1:0] mRegs [c_nreg];
    bit                mBusy [c_nreg];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(c_xlen), .NREG(c_nreg), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rSel1(rSel1), .rSel2(rSel2),
        .rs1Data(rs1Data), .rs2Data(rs2Data),
        .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
        .wCtrl(wCtrl), .wSel(wSel), .wData(wData),
        .issueValid(issueValid), .issueRd(issueRd),
        .flush(flush), .busyCount(busyCount)
    );

    regfile_sb #(.XLEN(c_xlen), .NREG(c_nreg), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst),
        .rSel1(rSel1), .rSel2(rSel2),
        .rs1Data(rs1Data0), .rs2Data(rs2Data0),
        .rs1Busy(rs1Busy0), .rs2Busy(rs2Busy0),
        .wCtrl(wCtrl), .wSel(wSel), .wData(wData),
        .issueValid(issueValid), .issueRd(issueRd),
        .flush(flush), .busyCount(busyCount0)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit fwd(input logic [c_aw-1:0] sel, input bit byp);
        return byp && wCtrl && (wSel != 0) && (sel == wSel);
    endfunction

    function automatic logic [31:0] expData(input logic [c_aw-1:0] sel,
                                            input bit byp);
        if (sel == 0) return 32'd0;
        if (fwd(sel, byp)) return wData;
        return mRegs[sel];
    endfunction

    function automatic logic [31:0] expBusy(input logic [c_aw-1:0] sel,
                                            input bit byp);
        if (sel == 0 || fwd(sel, byp)) return 32'd0;
        return {31'd0, mBusy[sel]};
    endfunction

    function automatic logic [31:0] expCount();
        int n = 0;
        for (int i = 0; i < c_nreg; i++) n += int'(mBusy[i]);
        return n;
    endfunction

    task automatic modelUpdate();
        if (!rst) begin
            for (int i = 0; i < c_nreg; i++) begin
                mRegs[i] = '0;
                mBusy[i] = 1'b0;
            end
        end else begin
            if (wCtrl && wSel != 0) mRegs[wSel] = wData;
            if (flush) begin
                for (int i = 0; i < c_nreg; i++) mBusy[i] = 1'b0;
            end else begin
                if (wCtrl && wSel != 0) mBusy[wSel] = 1'b0;
                if (issueValid && issueRd != 0) mBusy[issueRd] = 1'b1;
            end
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic checkAll();
        checkVal("rs1Data", rs1Data, expData(rSel1, 1'b1));
        checkVal("rs2Data", rs2Data, expData(rSel2, 1'b1));
        checkVal("rs1Busy", {31'd0, rs1Busy}, expBusy(rSel1, 1'b1));
        checkVal("rs2Busy", {31'd0, rs2Busy}, expBusy(rSel2, 1'b1));
        checkVal("busyCount", {26'd0, busyCount}, expCount());
        checkVal("nb_rs1Data", rs1Data0, expData(rSel1, 1'b0));
        checkVal("nb_rs2Data", rs2Data0, expData(rSel2, 1'b0));
        checkVal("nb_rs1Busy", {31'd0, rs1Busy0}, expBusy(rSel1, 1'b0));
        checkVal("nb_rs2Busy", {31'd0, rs2Busy0}, expBusy(rSel2, 1'b0));
        checkVal("nb_busyCount", {26'd0, busyCount0}, expCount());
    endtask

    task automatic sample();
        @(negedge clk);
        checkAll();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic idle();
        wCtrl = 0; wSel = '0; wData = '0;
        issueValid = 0; issueRd = '0; flush = 0;
    endtask

    initial begin
        rst = 0; rSel1 = '0; rSel2 = '0;
        idle();
        clockEdge();

        // Reset state
        sample();
        checkVal("reset_rs1Data", rs1Data, 32'd0);
        checkVal("reset_busyCount", {26'd0, busyCount}, 32'd0);
        clockEdge();
        rst = 1;

        // Write reg5, read back next cycle
        wCtrl = 1; wSel = 5'd5; wData = 32'hDEADBEEF;
        sample(); clockEdge();
        idle(); rSel1 = 5'd5;
        sample();
        checkVal("r5_data", rs1Data, 32'hDEADBEEF);
        checkVal("r5_busy", {31'd0, rs1Busy}, 32'd0);
        clockEdge();

        // Register 0 ignores writes and issues
        wCtrl = 1; wSel = 5'd0; wData = 32'hFFFFFFFF;
        sample(); clockEdge();
        idle(); rSel1 = 5'd0; issueValid = 1; issueRd = 5'd0;
        sample();
        checkVal("r0_data", rs1Data, 32'd0);
        clockEdge();
        idle();
        sample();
        checkVal("r0_count", {26'd0, busyCount}, 32'd0);
        checkVal("r0_busy", {31'd0, rs1Busy}, 32'd0);
        clockEdge();

        // Issue rd=7, then writeback with forwarding
        issueValid = 1; issueRd = 5'd7;
        sample(); clockEdge();
        idle(); rSel2 = 5'd7;
        sample();
        checkVal("r7_busy", {31'd0, rs2Busy}, 32'd1);
        checkVal("r7_count", {26'd0, busyCount}, 32'd1);
        wCtrl = 1; wSel = 5'd7; wData = 32'h1234;
        #1;
        checkVal("r7_fwd_data", rs2Data, 32'h1234);
        checkVal("r7_fwd_busy", {31'd0, rs2Busy}, 32'd0);
        checkVal("r7_nofwd_busy", {31'd0, rs2Busy0}, 32'd1);
        checkVal("r7_nofwd_data", rs2Data0, 32'd0);
        clockEdge();
        idle();
        sample();
        checkVal("r7_count_after", {26'd0, busyCount}, 32'd0);
        clockEdge();

        // Issue and write the same register together
        issueValid = 1; issueRd = 5'd3; wCtrl = 1; wSel = 5'd3; wData = 32'hA;
        rSel1 = 5'd3;
        sample(); clockEdge();
        idle();
        sample();
        checkVal("r3_data", rs1Data, 32'hA);
        checkVal("r3_busy", {31'd0, rs1Busy}, 32'd1);
        checkVal("r3_count", {26'd0, busyCount}, 32'd1);
        clockEdge();

        // Several issues, then flush with a dropped issue and a live write
        for (int k = 0; k < 3; k++) begin
            issueValid = 1; issueRd = 5'(1 << k);
            sample(); clockEdge();
        end
        flush = 1; issueValid = 1; issueRd = 5'd6;
        wCtrl = 1; wSel = 5'd2; wData = 32'hCAFE;
        sample(); clockEdge();
        idle(); rSel1 = 5'd6; rSel2 = 5'd2;
        sample();
        checkVal("flush_count", {26'd0, busyCount}, 32'd0);
        checkVal("flush_r6_busy", {31'd0, rs1Busy}, 32'd0);
        checkVal("flush_r2_data", rs2Data, 32'hCAFE);
        checkVal("flush_r2_busy", {31'd0, rs2Busy}, 32'd0);
        clockEdge();

        // Reset dominates a concurrent write and issue
        issueValid = 1; issueRd = 5'd10;
        sample(); clockEdge();
        rst = 0; wCtrl = 1; wSel = 5'd9; wData = 32'h55;
        issueValid = 1; issueRd = 5'd11; flush = 0;
        sample(); clockEdge();
        rst = 1; idle(); rSel1 = 5'd9; rSel2 = 5'd10;
        sample();
        checkVal("rst_r9_data", rs1Data, 32'd0);
        checkVal("rst_r10_busy", {31'd0, rs2Busy}, 32'd0);
        checkVal("rst_count", {26'd0, busyCount}, 32'd0);
        clockEdge();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 59) != 0);
            wCtrl      = ($urandom_range(0, 1) == 1);
            wSel       = 5'($urandom_range(0, c_nreg - 1));
            wData      = $urandom;
            issueValid = ($urandom_range(0, 2) != 0);
            issueRd    = 5'($urandom_range(0, c_nreg - 1));
            flush      = ($urandom_range(0, 24) == 0);
            rSel1      = ($urandom_range(0, 3) == 0) ? wSel
                                                      : 5'($urandom_range(0, c_nreg - 1));
            rSel2      = ($urandom_range(0, 3) == 0) ? issueRd
                                                      : 5'($urandom_range(0, c_nreg - 1));
            sample();
            clockEdge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
